// File: rtl/pid_incr_core.sv
// Velocity-form PID stage: one sample per handshake, a single shared 16x18 signed
// multiplier, and six FSM states from accept to output update.
module pid_incr_core #(
    parameter int FRAC = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               sample_valid,
    input  logic signed [15:0] setpoint,
    input  logic signed [15:0] feedback,
    input  logic signed [15:0] kp,
    input  logic signed [15:0] ki,
    input  logic signed [15:0] kd,
    output logic signed [15:0] u_out,
    output logic               out_valid,
    output logic               busy,
    output logic               sat
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_MP,
        S_MI,
        S_MD,
        S_UPD
    } state_t;

    state_t state, state_next;

    logic signed [15:0] sp_q, fb_q, kp_q, ki_q, kd_q;
    logic signed [15:0] e0, e1, e2;
    logic signed [16:0] d1;
    logic signed [17:0] d2;
    logic signed [35:0] acc;

    logic        [16:0] err_diff;
    logic signed [15:0] e0_next;
    logic signed [16:0] d1_next;
    logic signed [17:0] d2_next;
    logic signed [15:0] mul_a;
    logic signed [17:0] mul_b;
    logic signed [33:0] mul_a_x, mul_b_x, product;
    logic signed [35:0] prod_ext;
    logic signed [35:0] du;
    logic signed [39:0] u_sum;
    logic               clip_hi, clip_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            // NOTE: every clocked assignment is non-blocking so all registers see pre-edge values.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first, otherwise an unlisted path would infer a latch.
        state_next = state;
        if (clr) begin
            state_next = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (sample_valid) state_next = S_ERR;
                S_ERR:   state_next = S_MP;
                S_MP:    state_next = S_MI;
                S_MI:    state_next = S_MD;
                S_MD:    state_next = S_UPD;
                S_UPD:   state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Error is formed at 17 bits and clipped back to the 16-bit range.
    always_comb begin
        err_diff = {sp_q[15], sp_q} - {fb_q[15], fb_q};
        if (err_diff[16] != err_diff[15]) begin
            e0_next = err_diff[16] ? 16'sh8000 : 16'sh7fff;
        end else begin
            e0_next = err_diff[15:0];
        end
        d1_next = {e0_next[15], e0_next} - {e1[15], e1};
        d2_next = {{2{e0_next[15]}}, e0_next} - {e1[15], e1, 1'b0} + {{2{e2[15]}}, e2};
    end

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        unique case (state)
            S_MP: begin
                mul_a = kp_q;
                mul_b = {d1[16], d1};
            end
            S_MI: begin
                mul_a = ki_q;
                mul_b = {{2{e0[15]}}, e0};
            end
            S_MD: begin
                mul_a = kd_q;
                mul_b = d2;
            end
            default: ;
        endcase
    end

    assign mul_a_x  = 34'(mul_a);
    assign mul_b_x  = 34'(mul_b);
    assign product  = mul_a_x * mul_b_x;
    assign prod_ext = {{2{product[33]}}, product};

    assign du      = acc >>> FRAC;
    assign u_sum   = {{24{u_out[15]}}, u_out} + {{4{du[35]}}, du};
    assign clip_hi = u_sum > 40'sd32767;
    assign clip_lo = u_sum < -40'sd32768;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sample/gain captures are reset too so no X can reach the multiplier.
            sp_q      <= '0;
            fb_q      <= '0;
            kp_q      <= '0;
            ki_q      <= '0;
            kd_q      <= '0;
            e0        <= '0;
            e1        <= '0;
            e2        <= '0;
            d1        <= '0;
            d2        <= '0;
            acc       <= '0;
            u_out     <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else if (clr) begin
            e1        <= '0;
            e2        <= '0;
            acc       <= '0;
            u_out     <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (sample_valid) begin
                        sp_q <= setpoint;
                        fb_q <= feedback;
                        kp_q <= kp;
                        ki_q <= ki;
                        kd_q <= kd;
                    end
                end
                S_ERR: begin
                    e0 <= e0_next;
                    d1 <= d1_next;
                    d2 <= d2_next;
                end
                S_MP: acc <= prod_ext;
                S_MI: acc <= acc + prod_ext;
                S_MD: acc <= acc + prod_ext;
                S_UPD: begin
                    if (clip_hi) begin
                        u_out <= 16'sh7fff;
                    end else if (clip_lo) begin
                        u_out <= 16'sh8000;
                    end else begin
                        u_out <= u_sum[15:0];
                    end
                    sat       <= clip_hi | clip_lo;
                    out_valid <= 1'b1;
                    e2        <= e1;
                    e1        <= e0;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_pid_incr_core.sv
// Self-checking bench for pid_incr_core: directed test-plan cases plus randomized
// samples scored against an arithmetic model of the velocity-form PID update.
module tb_pid_incr_core;

    localparam int FRAC = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               clr;
    logic               sample_valid;
    logic signed [15:0] setpoint, feedback, kp, ki, kd;
    logic signed [15:0] u_out;
    logic               out_valid, busy, sat;

    int vectors    = 0;
    int miscompares = 0;

    // Reference state: last output, last two errors, last saturation flag.
    longint m_u, m_e1, m_e2;
    bit     m_sat;

    pid_incr_core #(.FRAC(FRAC)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .sample_valid(sample_valid),
        .setpoint(setpoint), .feedback(feedback), .kp(kp), .ki(ki), .kd(kd),
        .u_out(u_out), .out_valid(out_valid), .busy(busy), .sat(sat)
    );

    always #5 clk = ~clk;

    function automatic longint clip16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset();
        m_u = 0; m_e1 = 0; m_e2 = 0; m_sat = 0;
    endtask

    task automatic model_step(input logic signed [15:0] sp, fb, gp, gi, gd);
        longint e0, acc, du, u_raw;
        e0    = clip16(longint'(sp) - longint'(fb));
        acc   = longint'(gp) * (e0 - m_e1) + longint'(gi) * e0
              + longint'(gd) * (e0 - 2 * m_e1 + m_e2);
        du    = acc >>> FRAC;  // floor division by 2**FRAC
        u_raw = m_u + du;
        m_sat = (u_raw != clip16(u_raw));
        m_u   = clip16(u_raw);
        m_e2  = m_e1;
        m_e1  = e0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && busy; i++) tick();
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_reset();
    endtask

    // Drives one sample, scrambles the inputs after acceptance, optionally pokes
    // sample_valid while busy, and reports the result and its latency (-1 = none).
    task automatic run_sample(input logic signed [15:0] sp, fb, gp, gi, gd,
                              input bit poke_busy,
                              output logic signed [15:0] u, output logic s, output int lat);
        wait_idle();
        setpoint = sp; feedback = fb; kp = gp; ki = gi; kd = gd;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        setpoint = 16'($urandom); feedback = 16'($urandom);
        kp = 16'($urandom); ki = 16'($urandom); kd = 16'($urandom);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (poke_busy && (c == 2 || c == 4)) sample_valid = 1'b1;
            tick();
            sample_valid = 1'b0;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        u = u_out;
        s = sat;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; sample_valid = 1'b0;
        setpoint = '0; feedback = '0; kp = '0; ki = '0; kd = '0;
        repeat (3) tick();
        vectors++;
        if ({u_out, out_valid, busy, sat} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_state: u_out=%0d out_valid=%b busy=%b sat=%b, required all 0",
                     u_out, out_valid, busy, sat);
        end
        rst_n = 1'b1;
        tick();
        model_reset();
    endtask

    task automatic test_proportional();
        logic signed [15:0] u; logic s; int lat;
        do_clear();
        for (int n = 0; n < 2; n++) begin
            run_sample(16'sd100, 16'sd0, 16'sh0100, 16'sd0, 16'sd0, 1'b0, u, s, lat);
            vectors++;
            if (u !== 16'sd100 || s !== 1'b0 || lat !== 5) begin
                miscompares++;
                $display("FAIL proportional[%0d]: u=%0d sat=%b lat=%0d, required u=100 sat=0 lat=5",
                         n, u, s, lat);
            end
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL out_valid_pulse_width: out_valid=%b one cycle after pulse, required 0", out_valid);
        end
    endtask

    task automatic test_integral();
        logic signed [15:0] u; logic s; int lat;
        logic signed [15:0] sps [4] = '{16'sd10, 16'sd10, 16'sd10, -16'sd10};
        logic signed [15:0] exp_u [4] = '{16'sd5, 16'sd10, 16'sd15, 16'sd10};
        do_clear();
        for (int n = 0; n < 4; n++) begin
            run_sample(sps[n], 16'sd0, 16'sd0, 16'sh0080, 16'sd0, 1'b0, u, s, lat);
            vectors++;
            if (u !== exp_u[n] || s !== 1'b0 || lat !== 5) begin
                miscompares++;
                $display("FAIL integral[%0d]: u=%0d sat=%b lat=%0d, required u=%0d sat=0 lat=5",
                         n, u, s, lat, exp_u[n]);
            end
        end
    endtask

    task automatic test_derivative();
        logic signed [15:0] u; logic s; int lat;
        logic signed [15:0] exp_u [3] = '{16'sd10, 16'sd0, 16'sd0};
        do_clear();
        for (int n = 0; n < 3; n++) begin
            run_sample(16'sd10, 16'sd0, 16'sd0, 16'sd0, 16'sh0100, 1'b0, u, s, lat);
            vectors++;
            if (u !== exp_u[n] || s !== 1'b0 || lat !== 5) begin
                miscompares++;
                $display("FAIL derivative[%0d]: u=%0d sat=%b lat=%0d, required u=%0d sat=0 lat=5",
                         n, u, s, lat, exp_u[n]);
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [15:0] u; logic s; int lat;
        do_clear();
        run_sample(16'sd32767, -16'sd32768, 16'sh0200, 16'sd0, 16'sd0, 1'b0, u, s, lat);
        vectors++;
        if (u !== 16'sd32767 || s !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_positive: u=%0d sat=%b, required u=32767 sat=1", u, s);
        end
        do_clear();
        run_sample(-16'sd32768, 16'sd32767, 16'sh0200, 16'sd0, 16'sd0, 1'b0, u, s, lat);
        vectors++;
        if (u !== -16'sd32768 || s !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_negative: u=%0d sat=%b, required u=-32768 sat=1", u, s);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int at [3] = '{0, 0, 0};
        int exp_at [3] = '{6, 12, 18};
        longint exp_u [3];
        logic signed [15:0] got_u [3];
        do_clear();
        for (int n = 0; n < 3; n++) begin
            model_step(16'sd300, 16'sd100, 16'sh0180, 16'sh0040, 16'sh0020);
            exp_u[n] = m_u;
        end
        setpoint = 16'sd300; feedback = 16'sd100; kp = 16'sh0180; ki = 16'sh0040; kd = 16'sh0020;
        sample_valid = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (out_valid) begin
                if (pulses < 3) begin
                    at[pulses] = c;
                    got_u[pulses] = u_out;
                end
                pulses++;
                if (pulses == 3) sample_valid = 1'b0;
            end
        end
        sample_valid = 1'b0;
        vectors++;
        if (pulses !== 3) begin
            miscompares++;
            $display("FAIL held_valid_count: %0d results, required 3", pulses);
        end
        for (int n = 0; n < 3; n++) begin
            vectors++;
            if (at[n] !== exp_at[n] || longint'(got_u[n]) !== exp_u[n]) begin
                miscompares++;
                $display("FAIL held_valid[%0d]: cycle=%0d u=%0d, required cycle=%0d u=%0d",
                         n, at[n], got_u[n], exp_at[n], exp_u[n]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic signed [15:0] u; logic s; int lat;
        int extra = 0;
        do_clear();
        model_step(16'sd500, -16'sd200, 16'sh0100, 16'sh0010, 16'sh0008);
        run_sample(16'sd500, -16'sd200, 16'sh0100, 16'sh0010, 16'sh0008, 1'b1, u, s, lat);
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_valid) extra++;
        end
        vectors++;
        if (longint'(u) !== m_u || s !== m_sat || lat !== 5 || extra !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_ignore: u=%0d lat=%0d extra=%0d busy=%b, required u=%0d lat=5 extra=0 busy=0",
                     u, lat, extra, busy, m_u);
        end
    endtask

    task automatic test_random();
        logic signed [15:0] u; logic s; int lat;
        logic signed [15:0] sp, fb, gp, gi, gd;
        do_clear();
        for (int n = 0; n < 40; n++) begin
            sp = 16'($urandom);
            fb = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                gp = 16'($urandom); gi = 16'($urandom); gd = 16'($urandom);
            end else begin
                gp = 16'($signed($urandom_range(0, 1023)) - 512);
                gi = 16'($signed($urandom_range(0, 255)) - 128);
                gd = 16'($signed($urandom_range(0, 511)) - 256);
            end
            model_step(sp, fb, gp, gi, gd);
            run_sample(sp, fb, gp, gi, gd, 1'($urandom_range(0, 1)), u, s, lat);
            vectors++;
            if (longint'(u) !== m_u || s !== m_sat || lat !== 5) begin
                miscompares++;
                $display("FAIL random[%0d]: u=%0d sat=%b lat=%0d, required u=%0d sat=%b lat=5",
                         n, u, s, lat, m_u, m_sat);
            end
        end
    endtask

    task automatic test_midreset();
        logic signed [15:0] u; logic s; int lat;
        do_clear();
        run_sample(16'sd1000, 16'sd0, 16'sh0100, 16'sd0, 16'sd0, 1'b0, u, s, lat);
        wait_idle();
        setpoint = 16'sd2000; feedback = 16'sd0; kp = 16'sh0100; ki = 16'sd0; kd = 16'sd0;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({u_out, out_valid, busy, sat} !== 19'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: u_out=%0d out_valid=%b busy=%b sat=%b, required all 0",
                     u_out, out_valid, busy, sat);
        end
        tick();
        rst_n = 1'b1;
        tick();
        model_reset();
        model_step(16'sd1000, 16'sd0, 16'sh0100, 16'sd0, 16'sd0);
        run_sample(16'sd1000, 16'sd0, 16'sh0100, 16'sd0, 16'sd0, 1'b0, u, s, lat);
        vectors++;
        if (longint'(u) !== m_u || lat !== 5) begin
            miscompares++;
            $display("FAIL midreset_first_sample: u=%0d lat=%0d, required u=%0d lat=5", u, lat, m_u);
        end
    endtask

    task automatic test_clr();
        logic signed [15:0] u; logic s; int lat;
        int stray = 0;
        do_clear();
        run_sample(16'sd800, 16'sd0, 16'sh0100, 16'sd0, 16'sd0, 1'b0, u, s, lat);
        wait_idle();
        setpoint = 16'sd50; feedback = 16'sd0;
        clr = 1'b1;
        sample_valid = 1'b1;
        tick();
        clr = 1'b0;
        sample_valid = 1'b0;
        vectors++;
        if (u_out !== 16'sd0 || busy !== 1'b0 || sat !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_with_sample: u_out=%0d busy=%b sat=%b, required 0 0 0", u_out, busy, sat);
        end
        // Clear again while a sample is mid-compute; it must vanish.
        setpoint = 16'sd900;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (out_valid) stray++;
        end
        vectors++;
        if (stray !== 0 || u_out !== 16'sd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_discard: stray=%0d u_out=%0d busy=%b, required 0 0 0", stray, u_out, busy);
        end
        model_reset();
        model_step(16'sd40, 16'sd10, 16'sh0100, 16'sh0040, 16'sh0100);
        run_sample(16'sd40, 16'sd10, 16'sh0100, 16'sh0040, 16'sh0100, 1'b0, u, s, lat);
        vectors++;
        if (longint'(u) !== m_u || lat !== 5) begin
            miscompares++;
            $display("FAIL clr_history: u=%0d lat=%0d, required u=%0d lat=5", u, lat, m_u);
        end
    endtask

    initial begin
        test_reset();
        test_proportional();
        test_integral();
        test_derivative();
        test_saturation();
        test_back_to_back();
        test_busy_ignore();
        test_random();
        test_midreset();
        test_clr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
